// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between execute and the data RAM.
// Buffers stores, drains them under a valid/ready handshake, stalls the
// pipeline when full or fencing, and forwards pending store bytes into loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req_i,
    input  logic [31:0] wr_addr_i,
    input  logic [3:0]  wr_sel_i,
    input  logic [31:0] wr_data_i,
    input  logic        fence_i,
    output logic        hold_flag_o,
    output logic        ram_wr_en_o,
    output logic [31:0] ram_wr_addr_o,
    output logic [3:0]  ram_wr_sel_o,
    output logic [31:0] ram_wr_data_o,
    input  logic        ram_wr_ready_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_ram_data_i,
    output logic [31:0] ld_data_o,
    output logic        empty_o
);

    localparam logic [PTR_W:0]   LP_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   LP_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] LP_PTR_ONE = PTR_W'(1);

    logic [31:0]      r_addr [DEPTH];
    logic [3:0]       r_sel  [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_nonempty;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_idx;
    logic [31:0]      w_ld_data;

    assign w_full     = (r_count == LP_FULL);
    assign w_nonempty = (r_count != '0);
    // A full buffer refuses the store even if the head retires this cycle.
    assign w_push     = wr_req_i & ~w_full;
    assign w_pop      = w_nonempty & ram_wr_ready_i;

    assign ram_wr_en_o   = w_nonempty;
    assign ram_wr_addr_o = r_addr[r_rd_ptr];
    assign ram_wr_sel_o  = r_sel[r_rd_ptr];
    assign ram_wr_data_o = r_data[r_rd_ptr];
    assign empty_o       = ~w_nonempty;
    assign hold_flag_o   = (wr_req_i & w_full) | (fence_i & w_nonempty);
    assign ld_data_o     = w_ld_data;

    // Pointer and occupancy tracking; reset discards everything pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LP_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - LP_CNT_ONE;
            end
        end
    end

    // Entry storage: capture the store at the tail slot on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_sel[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (w_push) begin
            r_addr[r_wr_ptr] <= wr_addr_i;
            r_sel[r_wr_ptr]  <= wr_sel_i;
            r_data[r_wr_ptr] <= wr_data_i;
        end
    end

    // Load forwarding: walk valid entries oldest to youngest so the youngest matching byte wins.
    always_comb begin
        w_ld_data = ld_ram_data_i;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + i[PTR_W-1:0];
            if ((i[PTR_W:0] < r_count) && (r_addr[w_idx][31:2] == ld_addr_i[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_sel[w_idx][b]) begin
                        w_ld_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req_i;
    logic [31:0] wr_addr_i;
    logic [3:0]  wr_sel_i;
    logic [31:0] wr_data_i;
    logic        fence_i;
    logic        hold_flag_o;
    logic        ram_wr_en_o;
    logic [31:0] ram_wr_addr_o;
    logic [3:0]  ram_wr_sel_o;
    logic [31:0] ram_wr_data_o;
    logic        ram_wr_ready_i;
    logic [31:0] ld_addr_i;
    logic [31:0] ld_ram_data_i;
    logic [31:0] ld_data_o;
    logic        empty_o;

    int total = 0;
    int bad   = 0;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_req_i       (wr_req_i),
        .wr_addr_i      (wr_addr_i),
        .wr_sel_i       (wr_sel_i),
        .wr_data_i      (wr_data_i),
        .fence_i        (fence_i),
        .hold_flag_o    (hold_flag_o),
        .ram_wr_en_o    (ram_wr_en_o),
        .ram_wr_addr_o  (ram_wr_addr_o),
        .ram_wr_sel_o   (ram_wr_sel_o),
        .ram_wr_data_o  (ram_wr_data_o),
        .ram_wr_ready_i (ram_wr_ready_i),
        .ld_addr_i      (ld_addr_i),
        .ld_ram_data_i  (ld_ram_data_i),
        .ld_data_o      (ld_data_o),
        .empty_o        (empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        wr_req_i  = 1'b1;
        wr_addr_i = a;
        wr_sel_i  = s;
        wr_data_i = d;
    endtask

    initial begin
        rst_n          = 1'b0;
        wr_req_i       = 1'b0;
        wr_addr_i      = '0;
        wr_sel_i       = '0;
        wr_data_i      = '0;
        fence_i        = 1'b0;
        ram_wr_ready_i = 1'b0;
        ld_addr_i      = 32'h0000_0100;
        ld_ram_data_i  = 32'hCAFE_F00D;

        // Reset state
        tick();
        settle();
        chk("rst_empty", {31'd0, empty_o}, 32'd1);
        chk("rst_en", {31'd0, ram_wr_en_o}, 32'd0);
        chk("rst_hold", {31'd0, hold_flag_o}, 32'd0);
        chk("rst_addr", ram_wr_addr_o, 32'd0);
        chk("rst_sel", {28'd0, ram_wr_sel_o}, 32'd0);
        chk("rst_data", ram_wr_data_o, 32'd0);
        chk("rst_ld", ld_data_o, 32'hCAFE_F00D);
        rst_n = 1'b1;
        tick();

        // 1. Reset mid-drain
        ram_wr_ready_i = 1'b0;
        drive_store(32'h0000_0040, 4'hF, 32'h1111_1111); tick();
        drive_store(32'h0000_0044, 4'hF, 32'h2222_2222); tick();
        drive_store(32'h0000_0048, 4'hF, 32'h3333_3333); tick();
        wr_req_i = 1'b0;
        settle();
        chk("t1_pending_en", {31'd0, ram_wr_en_o}, 32'd1);
        chk("t1_pending_addr", ram_wr_addr_o, 32'h0000_0040);
        rst_n = 1'b0;
        settle();
        chk("t1_async_empty", {31'd0, empty_o}, 32'd1);
        chk("t1_async_en", {31'd0, ram_wr_en_o}, 32'd0);
        chk("t1_async_addr", ram_wr_addr_o, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t1_after_empty", {31'd0, empty_o}, 32'd1);
        chk("t1_after_en", {31'd0, ram_wr_en_o}, 32'd0);

        // 2. Single SW
        ram_wr_ready_i = 1'b1;
        drive_store(32'h0000_0100, 4'hF, 32'hDEAD_BEEF);
        settle();
        chk("t2_pre_en", {31'd0, ram_wr_en_o}, 32'd0);
        chk("t2_pre_hold", {31'd0, hold_flag_o}, 32'd0);
        tick();
        wr_req_i = 1'b0;
        settle();
        chk("t2_en", {31'd0, ram_wr_en_o}, 32'd1);
        chk("t2_addr", ram_wr_addr_o, 32'h0000_0100);
        chk("t2_sel", {28'd0, ram_wr_sel_o}, 32'h0000_000F);
        chk("t2_data", ram_wr_data_o, 32'hDEAD_BEEF);
        tick();
        chk("t2_empty", {31'd0, empty_o}, 32'd1);
        chk("t2_en_off", {31'd0, ram_wr_en_o}, 32'd0);

        // 3. Fill with RAM stalled, then drain
        ram_wr_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h0000_0400 + 32'(4*i), 4'hF, 32'h0000_1000 + 32'(i));
            settle();
            chk("t3_fill_hold", {31'd0, hold_flag_o}, 32'd0);
            tick();
        end
        drive_store(32'h0000_0410, 4'hF, 32'h0000_1004);
        settle();
        chk("t3_full_hold", {31'd0, hold_flag_o}, 32'd1);
        tick();
        chk("t3_full_hold2", {31'd0, hold_flag_o}, 32'd1);
        ram_wr_ready_i = 1'b1;
        settle();
        chk("t3_full_pop_hold", {31'd0, hold_flag_o}, 32'd1);
        chk("t3_head0", ram_wr_addr_o, 32'h0000_0400);
        tick();
        chk("t3_after_pop_hold", {31'd0, hold_flag_o}, 32'd0);
        chk("t3_head1", ram_wr_addr_o, 32'h0000_0404);
        tick();
        wr_req_i = 1'b0;
        settle();
        chk("t3_head2", ram_wr_addr_o, 32'h0000_0408);
        tick();
        chk("t3_head3", ram_wr_addr_o, 32'h0000_040C);
        tick();
        chk("t3_head4_addr", ram_wr_addr_o, 32'h0000_0410);
        chk("t3_head4_data", ram_wr_data_o, 32'h0000_1004);
        tick();
        chk("t3_empty", {31'd0, empty_o}, 32'd1);

        // 4. Forward merge
        ram_wr_ready_i = 1'b0;
        drive_store(32'h0000_0200, 4'b0001, 32'h0000_0011); tick();
        drive_store(32'h0000_0202, 4'b1100, 32'hAABB_0000); tick();
        wr_req_i      = 1'b0;
        ld_addr_i     = 32'h0000_0200;
        ld_ram_data_i = 32'h1234_5678;
        settle();
        chk("t4_merge", ld_data_o, 32'hAABB_5611);
        ld_addr_i = 32'h0000_0204;
        settle();
        chk("t4_nomatch", ld_data_o, 32'h1234_5678);
        ld_addr_i = 32'h0000_0200;
        drive_store(32'h0000_0201, 4'b0010, 32'h0000_CC00);
        settle();
        chk("t4_same_cycle_push", ld_data_o, 32'hAABB_5611);
        tick();
        wr_req_i = 1'b0;
        settle();
        chk("t4_after_push", ld_data_o, 32'hAABB_CC11);
        ram_wr_ready_i = 1'b1;
        settle();
        chk("t4_popping_fwd", ld_data_o, 32'hAABB_CC11);
        tick();
        chk("t4_after_pop", ld_data_o, 32'hAABB_CC78);
        chk("t4_head_addr_lsb", ram_wr_addr_o, 32'h0000_0202);
        tick();
        tick();
        chk("t4_empty", {31'd0, empty_o}, 32'd1);

        // 5. Youngest wins
        ram_wr_ready_i = 1'b0;
        drive_store(32'h0000_0300, 4'b0010, 32'h0000_2200); tick();
        drive_store(32'h0000_0300, 4'b0010, 32'h0000_3300); tick();
        wr_req_i      = 1'b0;
        ld_addr_i     = 32'h0000_0300;
        ld_ram_data_i = 32'h0000_0000;
        settle();
        chk("t5_youngest", ld_data_o, 32'h0000_3300);

        // 6. Fence drains the two pending stores
        fence_i        = 1'b1;
        ram_wr_ready_i = 1'b1;
        settle();
        chk("t6_hold_c0", {31'd0, hold_flag_o}, 32'd1);
        tick();
        chk("t6_hold_c1", {31'd0, hold_flag_o}, 32'd1);
        chk("t6_fwd_c1", ld_data_o, 32'h0000_3300);
        tick();
        chk("t6_hold_c2", {31'd0, hold_flag_o}, 32'd0);
        chk("t6_empty", {31'd0, empty_o}, 32'd1);
        chk("t6_ld_raw", ld_data_o, 32'h0000_0000);
        fence_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
